// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_defs: shared definitions for the hardwired control sequencer.
//   - 4-bit state encoding (RST, T0..T6, HALT, FAULT)
//   - opcode constants and the opcode-class decode helper
//   - IR field bit positions (opcode, Ra, Rb, Rc)
// ---------------------------------------------------------------------------
package ctrl_defs;

  // State encoding. Plain localparams keep the encoding visible to legacy
  // tools and waveform viewers that do not understand enums.
  localparam logic [3:0] ST_RST   = 4'd0;
  localparam logic [3:0] ST_T0    = 4'd1;
  localparam logic [3:0] ST_T1    = 4'd2;
  localparam logic [3:0] ST_T2    = 4'd3;
  localparam logic [3:0] ST_T3    = 4'd4;
  localparam logic [3:0] ST_T4    = 4'd5;
  localparam logic [3:0] ST_T5    = 4'd6;
  localparam logic [3:0] ST_T6    = 4'd7;
  localparam logic [3:0] ST_HALT  = 4'd8;
  localparam logic [3:0] ST_FAULT = 4'd9;

  // Opcodes and class ranges.
  localparam logic [4:0] OP_ALU_LO = 5'b00000;
  localparam logic [4:0] OP_ALU_HI = 5'b01011;
  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_NEG    = 5'b10000;
  localparam logic [4:0] OP_NOT    = 5'b10001;
  localparam logic [4:0] OP_NOP    = 5'b11010;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  // IR field positions (MSB of each field; fields extend downwards).
  localparam int OPC_MSB = 31;
  localparam int OPC_W   = 5;
  localparam int RA_MSB  = 26;
  localparam int RB_MSB  = 22;
  localparam int RC_MSB  = 18;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] opc);
    if (opc >= OP_ALU_LO && opc <= OP_ALU_HI) return CLS_ALU;
    if (opc == OP_MUL || opc == OP_DIV)        return CLS_MULDIV;
    if (opc == OP_NEG || opc == OP_NOT)        return CLS_UNARY;
    if (opc == OP_NOP)                         return CLS_NOP;
    if (opc == OP_HALT)                        return CLS_HALT;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/control_unit_reg_select_decode.sv
// ---------------------------------------------------------------------------
// reg_select_decode: ADDR_W-to-2^ADDR_W one-hot decoder with enable.
//   en_i     in  1         output is all-zero when low
//   sel_i    in  ADDR_W    register index
//   onehot_o out 2^ADDR_W  one-hot select
// ---------------------------------------------------------------------------
module reg_select_decode #(
  parameter int ADDR_W = 4
) (
  input  logic                   en_i,
  input  logic [ADDR_W-1:0]      sel_i,
  output logic [2**ADDR_W-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit: hardwired T-state sequencer driving the datapath strobes.
// Fetch (T0..T2) through PC/MAR/MDR into IR, then decode the live IR in T3
// and step the class-specific execute states. Outputs are a purely
// combinational decode of the registered state and IR.
//
// Ports
//   Clock, Resetn                 clock, async active-low reset
//   IR[31:0]                      instruction register from the datapath
//   MemReady                      memory data valid, sampled in T1
//   Stop                          halt request, honoured at instruction end
//   PCout PCin IncPC MARin        PC/MAR strobes
//   Read MDRin MDRout IRin        memory/IR strobes
//   Yin Zin Zlowout ZHighout
//   LOin HIin                     ALU register strobes
//   Rin, Rout [2^ADDR_W-1:0]      one-hot register load / drive selects
//   operation[4:0]                ALU op code (opcode in T3..T6, else 0)
//   Run                           high in T0..T6
//   Fault                         sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module control_unit
  import ctrl_defs::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [31:0]          IR,
  input  logic                 MemReady,
  input  logic                 Stop,
  output logic                 PCout,
  output logic                 PCin,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 Zlowout,
  output logic                 ZHighout,
  output logic                 LOin,
  output logic                 HIin,
  output logic [2**ADDR_W-1:0] Rin,
  output logic [2**ADDR_W-1:0] Rout,
  output logic [4:0]           operation,
  output logic                 Run,
  output logic                 Fault
);

  localparam int FIELD_LSB = RC_MSB - ADDR_W + 1;

  logic [3:0]        state_q, state_d;
  logic              stop_q,  stop_d;
  logic              fault_q, fault_d;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] ra, rb, rc;
  op_class_e         cls;
  logic              in_run;
  logic [3:0]        end_state;

  logic              rin_en, rout_en;
  logic [ADDR_W-1:0] rin_sel, rout_sel;

  // Low IR bits carry no control information.
  logic              unused_ir;
  assign unused_ir = ^IR[FIELD_LSB-1:0];

  assign opcode = IR[OPC_MSB -: OPC_W];
  assign ra     = IR[RA_MSB  -: ADDR_W];
  assign rb     = IR[RB_MSB  -: ADDR_W];
  assign rc     = IR[RC_MSB  -: ADDR_W];
  assign cls    = op_class(opcode);

  assign in_run = (state_q >= ST_T0) && (state_q <= ST_T6);

  // A Stop seen earlier in the instruction, or on this very edge, diverts
  // the instruction's last state to HALT instead of the next fetch.
  assign end_state = (stop_q || Stop) ? ST_HALT : ST_T0;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  if (MemReady) state_d = ST_T2;
      ST_T2:  state_d = ST_T3;
      ST_T3: begin
        unique case (cls)
          CLS_ALU, CLS_MULDIV, CLS_UNARY: state_d = ST_T4;
          CLS_NOP:                        state_d = end_state;
          CLS_HALT:                       state_d = ST_HALT;
          default:                        state_d = ST_FAULT;
        endcase
      end
      ST_T4:  state_d = (cls == CLS_UNARY) ? end_state : ST_T5;
      ST_T5:  state_d = (cls == CLS_MULDIV) ? ST_T6 : end_state;
      ST_T6:  state_d = end_state;
      ST_HALT, ST_FAULT: state_d = state_q;
      default: state_d = ST_RST;
    endcase
  end

  assign stop_d  = stop_q || (Stop && in_run);
  assign fault_d = fault_q || ((state_q == ST_T3) && (cls == CLS_ILLEGAL));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_RST;
      stop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      fault_q <= fault_d;
    end
  end

  // ---------------------------------------------------------------------
  // Strobe decode. Only one bus driver is ever active per state.
  // ---------------------------------------------------------------------
  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    rin_en   = 1'b0;
    rin_sel  = ra;
    rout_en  = 1'b0;
    rout_sel = rb;
    unique case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      // Held for every wait cycle; reloading PC from Z is idempotent.
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        unique case (cls)
          CLS_ALU:    begin rout_en = 1'b1; rout_sel = rb; Yin = 1'b1; end
          CLS_MULDIV: begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; end
          CLS_UNARY:  begin rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T4: begin
        unique case (cls)
          CLS_ALU:    begin rout_en = 1'b1; rout_sel = rc; Zin = 1'b1; end
          CLS_MULDIV: begin rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; end
          CLS_UNARY:  begin Zlowout = 1'b1; rin_en = 1'b1; end
          default:    ;
        endcase
      end
      ST_T5: begin
        unique case (cls)
          CLS_ALU:    begin Zlowout = 1'b1; rin_en = 1'b1; end
          CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T6: begin
        if (cls == CLS_MULDIV) begin
          ZHighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign operation = (state_q >= ST_T3 && state_q <= ST_T6) ? opcode : '0;
  assign Run       = in_run;
  assign Fault     = fault_q;

  reg_select_decode #(.ADDR_W(ADDR_W)) u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (rin_sel),
    .onehot_o (Rin)
  );

  reg_select_decode #(.ADDR_W(ADDR_W)) u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

endmodule
